// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the display time-share scheduler and its helpers.
package display_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  localparam logic [3:0]  LES_BLANK = 4'hF;
  localparam logic [15:0] HEX_BLANK = 16'h0;
  localparam int          MAX_NREQ  = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/display_arbiter_if.sv
// Requester-side data and display-side outputs of the arbiter, bundled for port lists.
interface display_arbiter_if #(parameter int NREQ = 3);
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] req_hexs;
  logic [4*NREQ-1:0] req_points;
  logic [4*NREQ-1:0] req_les;
  logic [NREQ-1:0]   grant;
  logic [2:0]        owner;
  logic              busy;
  logic [15:0]       hexs;
  logic [3:0]        points;
  logic [3:0]        LEs;

  modport master (output req, req_hexs, req_points, req_les,
                  input  grant, owner, busy, hexs, points, LEs);
  modport slave  (input  req, req_hexs, req_points, req_les,
                  output grant, owner, busy, hexs, points, LEs);
endinterface

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin search: first set request after i_last, wrapping modulo NREQ.
module rr_picker
  import display_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic            o_found,
  output logic [IW-1:0]   o_idx
);
  always_comb begin : pick
    logic [IW-1:0] w_j;
    w_j     = '0;
    o_found = 1'b0;
    o_idx   = '0;
    // Walk from farthest to nearest so the closest hit after i_last wins.
    for (int k = NREQ; k >= 1; k--) begin
      w_j = IW'((int'(i_last) + k) % NREQ);
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end
endmodule

// File: rtl/display_arbiter.sv
// Round-robin time-share of one 4-digit seven-segment driver among NREQ requesters,
// with a DWELL-cycle ownership slot and an optional GAP-cycle blank between owners.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DWELL = 50000000,
  parameter int GAP   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  display_arbiter_if.slave bus
);
  localparam int IW   = idx_w(NREQ);
  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);

  state_t              r_state, w_state_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic [IW-1:0]       r_owner, w_owner_n;
  logic [IW-1:0]       r_ptr, w_ptr_n;
  logic [NREQ-1:0]     r_grant, w_grant_n;
  logic                r_busy, w_busy_n;
  logic [15:0]         r_hexs, w_hexs_n;
  logic [3:0]          r_points, w_points_n;
  logic [3:0]          r_les, w_les_n;

  logic [NREQ-1:0][15:0] w_hex_arr;
  logic [NREQ-1:0][3:0]  w_pt_arr;
  logic [NREQ-1:0][3:0]  w_le_arr;
  logic [NREQ-1:0]       w_pick_req;
  logic                  w_own_req, w_found, w_take, w_keep;
  logic [IW-1:0]         w_win, w_sel;

  assign w_hex_arr  = bus.req_hexs;
  assign w_pt_arr   = bus.req_points;
  assign w_le_arr   = bus.req_les;
  assign w_own_req  = |(bus.req & r_grant);
  // Masking the current grant makes "others pending" and the plain pick share one search;
  // grant is zero outside SHOW, so the last owner is eligible again at GAP end.
  assign w_pick_req = bus.req & ~r_grant;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (w_pick_req),
    .i_last  (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_owner_n  = r_owner;
    w_ptr_n    = r_ptr;
    w_grant_n  = '0;
    w_busy_n   = 1'b0;
    w_hexs_n   = HEX_BLANK;
    w_points_n = '0;
    w_les_n    = LES_BLANK;
    w_take     = 1'b0;
    w_keep     = 1'b0;
    w_sel      = r_owner;

    unique case (r_state)
      S_IDLE: w_take = w_found;
      S_SHOW: begin
        if (!w_own_req || r_cnt == DWELL_LAST) begin
          if (w_found) begin
            if (GAP == 0) w_take = 1'b1;
            else begin
              w_state_n = S_GAP;
              w_cnt_n   = '0;
            end
          end else if (w_own_req) begin
            w_keep  = 1'b1;
            w_cnt_n = '0;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_keep  = 1'b1;
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_take = w_found;
          if (!w_found) w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_take) begin
      w_state_n = S_SHOW;
      w_cnt_n   = '0;
      w_owner_n = w_win;
      w_ptr_n   = w_win;
      w_sel     = w_win;
    end

    if (w_take || w_keep) begin
      w_grant_n  = w_take ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : r_grant;
      w_busy_n   = 1'b1;
      w_hexs_n   = w_hex_arr[w_sel];
      w_points_n = w_pt_arr[w_sel];
      w_les_n    = w_le_arr[w_sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_owner  <= '0;
      r_ptr    <= IW'(NREQ - 1);
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_hexs   <= HEX_BLANK;
      r_points <= '0;
      r_les    <= LES_BLANK;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_owner  <= w_owner_n;
      r_ptr    <= w_ptr_n;
      r_grant  <= w_grant_n;
      r_busy   <= w_busy_n;
      r_hexs   <= w_hexs_n;
      r_points <= w_points_n;
      r_les    <= w_les_n;
    end
  end

  assign bus.grant  = r_grant;
  assign bus.owner  = 3'(r_owner);
  assign bus.busy   = r_busy;
  assign bus.hexs   = r_hexs;
  assign bus.points = r_points;
  assign bus.LEs    = r_les;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench: idle/reset, self re-grant, rotation with gaps, early release,
// async reset mid-slot, and direct handover with GAP=0.
module tb_display_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  display_arbiter_if #(.NREQ(3)) ifa ();
  display_arbiter_if #(.NREQ(3)) ifb ();

  display_arbiter #(.NREQ(3), .DWELL(8), .GAP(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  display_arbiter #(.NREQ(3), .DWELL(8), .GAP(0)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int own, p;
    logic [31:0] eg, eh, el;

    ifa.req = '0; ifa.req_hexs = '0; ifa.req_points = '0; ifa.req_les = '0;
    ifb.req = '0; ifb.req_hexs = '0; ifb.req_points = '0; ifb.req_les = '0;

    // Reset held, then idle with no requests
    step(2);
    chk("rst_les",    32'(ifa.LEs), 'hF);
    chk("rst_hexs",   32'(ifa.hexs), 0);
    chk("rst_grant",  32'(ifa.grant), 0);
    chk("rst_busy",   32'(ifa.busy), 0);
    chk("rst_owner",  32'(ifa.owner), 0);
    chk("rst_points", 32'(ifa.points), 0);
    chk("rst_b_les",  32'(ifb.LEs), 'hF);
    #4 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("idle_les",   32'(ifa.LEs), 'hF);
      chk("idle_grant", 32'(ifa.grant), 0);
      chk("idle_busy",  32'(ifa.busy), 0);
    end

    // Single requester with self re-grant and live data update
    ifa.req_hexs[15:0]  = 16'h1234;
    ifa.req_points[3:0] = 4'h5;
    ifa.req_les[3:0]    = 4'h2;
    ifa.req = 3'b001;
    step(1);
    chk("one_grant",  32'(ifa.grant), 'b001);
    chk("one_owner",  32'(ifa.owner), 0);
    chk("one_busy",   32'(ifa.busy), 1);
    chk("one_hexs",   32'(ifa.hexs), 'h1234);
    chk("one_points", 32'(ifa.points), 'h5);
    chk("one_les",    32'(ifa.LEs), 'h2);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("regrant_grant", 32'(ifa.grant), 'b001);
      chk("regrant_les",   32'(ifa.LEs), 'h2);
    end
    ifa.req_hexs[15:0] = 16'hBEEF;
    chk("live_before", 32'(ifa.hexs), 'h1234);
    step(1);
    chk("live_after", 32'(ifa.hexs), 'hBEEF);
    ifa.req = '0;
    step(1);
    chk("drop_grant", 32'(ifa.grant), 0);
    chk("drop_les",   32'(ifa.LEs), 'hF);
    chk("drop_hexs",  32'(ifa.hexs), 0);
    chk("drop_busy",  32'(ifa.busy), 0);

    // Rotation from a fresh reset: 001,010,100,001 with two blank cycles between
    rst = 1'b0;
    step(1);
    #4 rst = 1'b1;
    ifa.req_hexs   = {16'h3333, 16'h2222, 16'h1111};
    ifa.req_les    = '0;
    ifa.req_points = '0;
    ifa.req = 3'b111;
    for (int c = 1; c <= 38; c++) begin
      step(1);
      p   = (c - 1) % 10;
      own = ((c - 1) / 10) % 3;
      if (p < 8) begin
        eg = 32'(1) << own;
        eh = 32'h1111 * (own + 1);
        el = 0;
      end else begin
        eg = 0; eh = 0; el = 'hF;
      end
      chk("rot_grant", 32'(ifa.grant), eg);
      chk("rot_hexs",  32'(ifa.hexs), eh);
      chk("rot_les",   32'(ifa.LEs), el);
    end

    // Async reset in the middle of owner 1's slot, then early release
    ifa.req = '0;
    rst = 1'b0;
    step(1);
    #4 rst = 1'b1;
    ifa.req = 3'b110;
    step(1);
    chk("ar_grant0", 32'(ifa.grant), 'b010);
    chk("ar_hexs0",  32'(ifa.hexs), 'h2222);
    step(1);
    #3 rst = 1'b0;
    #1;
    chk("ar_async_grant", 32'(ifa.grant), 0);
    chk("ar_async_les",   32'(ifa.LEs), 'hF);
    chk("ar_async_hexs",  32'(ifa.hexs), 0);
    chk("ar_async_busy",  32'(ifa.busy), 0);
    step(1);
    chk("ar_held_grant", 32'(ifa.grant), 0);
    #4 rst = 1'b1;
    step(1);
    chk("ar_first_grant", 32'(ifa.grant), 'b010);
    chk("ar_first_owner", 32'(ifa.owner), 1);
    step(2);
    chk("er_c3_grant", 32'(ifa.grant), 'b010);
    ifa.req = 3'b100;
    step(1);
    chk("er_gap0_grant", 32'(ifa.grant), 0);
    chk("er_gap0_les",   32'(ifa.LEs), 'hF);
    chk("er_gap0_hexs",  32'(ifa.hexs), 0);
    chk("er_gap0_busy",  32'(ifa.busy), 0);
    chk("er_gap0_owner", 32'(ifa.owner), 1);
    step(1);
    chk("er_gap1_grant", 32'(ifa.grant), 0);
    chk("er_gap1_hexs",  32'(ifa.hexs), 0);
    step(1);
    chk("er_next_grant", 32'(ifa.grant), 'b100);
    chk("er_next_hexs",  32'(ifa.hexs), 'h3333);
    chk("er_next_owner", 32'(ifa.owner), 2);

    // GAP=0: direct handover between owners 0 and 1, no blank cycle
    ifb.req_hexs[15:0]  = 16'hAAAA;
    ifb.req_hexs[31:16] = 16'h5555;
    ifb.req_les = '0;
    ifb.req = 3'b011;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      own = ((c - 1) / 8) % 2;
      eg  = (own == 1) ? 'b010 : 'b001;
      eh  = (own == 1) ? 'h5555 : 'hAAAA;
      chk("g0_grant", 32'(ifb.grant), eg);
      chk("g0_hexs",  32'(ifb.hexs), eh);
      chk("g0_les",   32'(ifb.LEs), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
